// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: funct3 load/store width codes and FSM states.
package mem_responder_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      BITS8   = 3'b000,
      BITS16  = 3'b001,
      BITS32  = 3'b010,
      BITS8U  = 3'b100,
      BITS16U = 3'b101
   } mem_width_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } mem_resp_state_e;

endpackage

// File: rtl/mem_lane_extract.sv
// Combinational lane selection and sign/zero extension of a 32-bit word for a funct3 width,
// plus legality/misalignment flags and the aligned-down lane used for both loads and stores.
module mem_lane_extract
   import mem_responder_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [1:0]        lane,
   input  logic [2:0]        width,
   output logic [WORD_W-1:0] data,
   output logic              legal,
   output logic              misaligned,
   output logic [1:0]        lane_aligned
);

   logic [WORD_W-1:0] shifted;

   always_comb begin
      data         = '0;
      legal        = 1'b1;
      misaligned   = 1'b0;
      lane_aligned = lane;
      shifted      = '0;
      case (width)
         BITS16, BITS16U: begin
            misaligned   = lane[0];
            lane_aligned = {lane[1], 1'b0};
         end
         BITS32: begin
            misaligned   = (lane != 2'b00);
            lane_aligned = 2'b00;
         end
         BITS8, BITS8U: ;
         default: legal = 1'b0;
      endcase
      shifted = word >> {lane_aligned, 3'b000};
      case (width)
         BITS8:   data = {{24{shifted[7]}}, shifted[7:0]};
         BITS8U:  data = {24'd0, shifted[7:0]};
         BITS16:  data = {{16{shifted[15]}}, shifted[15:0]};
         BITS16U: data = {16'd0, shifted[15:0]};
         BITS32:  data = word;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// Valid/ready memory responder over a byte-addressed word array with WAIT_STATES access delay.
// MEM_RESPONDER_STRICT_EN: flag misaligned and out-of-range accesses as errors instead of aligning/wrapping.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_width,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam int IDX_HI = IDX_W + 1;

   mem_resp_state_e state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [31:0] rdata_reg, rdata_next;
   logic        err_reg, err_next;
   logic        we_reg;
   logic [31:0] addr_reg;
   logic [2:0]  width_reg;
   logic [31:0] wdata_reg;

   logic [31:0] mem [DEPTH_WORDS];
   logic [IDX_W-1:0] idx;
   logic [31:0] word, ext_data, wdata_rep, merged;
   logic [3:0]  be;
   logic [1:0]  lane_aligned;
   logic        legal, misaligned, access_err, commit, do_write;

   assign idx  = addr_reg[IDX_HI:2];
   assign word = mem[idx];

   mem_lane_extract u_extract (
      .word         (word),
      .lane         (addr_reg[1:0]),
      .width        (width_reg),
      .data         (ext_data),
      .legal        (legal),
      .misaligned   (misaligned),
      .lane_aligned (lane_aligned)
   );

`ifdef MEM_RESPONDER_STRICT_EN
   assign access_err = !legal || misaligned || (|addr_reg[31:IDX_HI+1]);
`else
   // Misaligned accesses are aligned down by the extractor; high address bits simply wrap.
   logic unused_addr_hi;
   assign unused_addr_hi = misaligned | (|addr_reg[31:IDX_HI+1]);
   assign access_err     = !legal;
`endif

   assign commit   = (state_reg == ACCESS) && (cnt_reg == 4'd0);
   assign do_write = commit && we_reg && !access_err;

   always_comb begin
      case (width_reg[1:0])
         2'b00:   begin be = 4'b0001 << lane_aligned; wdata_rep = {4{wdata_reg[7:0]}};  end
         2'b01:   begin be = 4'b0011 << lane_aligned; wdata_rep = {2{wdata_reg[15:0]}}; end
         default: begin be = 4'b1111;                 wdata_rep = wdata_reg;            end
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign merged[8*gi +: 8] = be[gi] ? wdata_rep[8*gi +: 8] : word[8*gi +: 8];
      end
   endgenerate

   // State resets asynchronously, so a store interrupted by reset never reaches this write.
   always_ff @(posedge clk) begin
      if (do_write) mem[idx] <= merged;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         rdata_reg <= '0;
         err_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         width_reg <= '0;
         wdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rdata_reg <= rdata_next;
         err_reg   <= err_next;
         if (req_ready && req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            width_reg <= req_width;
            wdata_reg <= req_wdata;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rdata_next = rdata_reg;
      err_next   = err_reg;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               state_next = ACCESS;
               cnt_next   = 4'(WAIT_STATES);
            end
         end
         ACCESS: begin
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               state_next = RESPOND;
               err_next   = access_err;
               rdata_next = (we_reg || access_err) ? 32'd0 : ext_data;
            end
         end
         RESPOND: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
               rdata_next = '0;
               err_next   = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign rsp_rdata = rdata_reg;
   assign rsp_err   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, stall/reset sequences, and
// randomized traffic checked against a byte-level memory model.
module tb_mem_responder;

   localparam int DEPTH = 256;
   localparam int WS    = 1;
   localparam int BYTES = DEPTH * 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_width = '0;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;

   int checks = 0;
   int failures = 0;
   bit strict;
   logic [7:0] mdl [BYTES];

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: little-endian byte array, computed from the access rules directly.
   function automatic void model(input logic we, input logic [31:0] addr, input logic [2:0] w,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic err);
      int unsigned size, a;
      logic illegal, mis, oor;
      illegal = (w == 3'd3) || (w == 3'd6) || (w == 3'd7);
      size = (w[1:0] == 2'd0) ? 1 : (w[1:0] == 2'd1) ? 2 : 4;
      mis = (addr % size) != 0;
      oor = addr >= BYTES;
      err = illegal || (strict && (mis || oor));
      rd = '0;
      if (err) return;
      a = addr % BYTES;
      a = a - (a % size);
      if (we) begin
         for (int i = 0; i < int'(size); i++) mdl[a+i] = wd[8*i +: 8];
      end else begin
         for (int i = 0; i < int'(size); i++) rd[8*i +: 8] = mdl[a+i];
         if (!w[2] && size == 1 && rd[7])  rd[31:8]  = '1;
         if (!w[2] && size == 2 && rd[15]) rd[31:16] = '1;
      end
   endfunction

   task automatic txn(input logic we, input logic [31:0] addr, input logic [2:0] w,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
      int n;
      @(negedge clk);
      req_we = we; req_addr = addr; req_width = w; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
      @(posedge clk); #1 req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("latency", 32'(n), 32'(WS + 1));
      repeat (hold) begin @(posedge clk); #1; end
      rd = rsp_rdata;
      er = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
      $display("txn we=%0b addr=%h w=%0d wdata=%h -> rdata=%h err=%0b", we, addr, w, wd, rd, er);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  w;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   initial begin
      vec_t vecs[12];
      logic [31:0] rd, mrd, held, first;
      logic er, merr;
      int n;
`ifdef MEM_RESPONDER_STRICT_EN
      strict = 1'b1;
`else
      strict = 1'b0;
`endif

      #2;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rdata", rsp_rdata, 32'd0);
      chk("reset_err", 32'(rsp_err), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Give the first 32 words defined contents.
      for (int i = 0; i < 32; i++) begin
         logic [31:0] d;
         d = $urandom;
         model(1'b1, 32'(4*i), 3'd2, d, mrd, merr);
         txn(1'b1, 32'(4*i), 3'd2, d, 0, rd, er);
         chk("init_rdata", rd, 32'd0);
         chk("init_err", 32'(er), 32'd0);
      end

      vecs[0]  = '{1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h11, 3'd0, 32'h80, 32'h0, 1'b0};
      vecs[3]  = '{1'b0, 32'h11, 3'd0, 32'h0, 32'hFFFFFF80, 1'b0};
      vecs[4]  = '{1'b0, 32'h11, 3'd4, 32'h0, 32'h00000080, 1'b0};
      vecs[5]  = '{1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD80EF, 1'b0};
      vecs[6]  = '{1'b0, 32'h12, 3'd1, 32'h0, 32'hFFFFDEAD, 1'b0};
      vecs[7]  = '{1'b0, 32'h12, 3'd5, 32'h0, 32'h0000DEAD, 1'b0};
      vecs[8]  = strict ? '{1'b0, 32'h13, 3'd1, 32'h0, 32'h0, 1'b1}
                        : '{1'b0, 32'h13, 3'd1, 32'h0, 32'hFFFFDEAD, 1'b0};
      vecs[9]  = '{1'b1, 32'h10, 3'd7, 32'h11223344, 32'h0, 1'b1};
      vecs[10] = '{1'b0, 32'h10, 3'd2, 32'h0, 32'hDEAD80EF, 1'b0};
      vecs[11] = strict ? '{1'b0, 32'h410, 3'd2, 32'h0, 32'h0, 1'b1}
                        : '{1'b0, 32'h410, 3'd2, 32'h0, 32'hDEAD80EF, 1'b0};
      for (int i = 0; i < 12; i++) begin
         model(vecs[i].we, vecs[i].addr, vecs[i].w, vecs[i].wd, mrd, merr);
         txn(vecs[i].we, vecs[i].addr, vecs[i].w, vecs[i].wd, 0, rd, er);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      end

      // Response stall: a pending request must wait for the handshake.
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h10; req_width = 3'd2; req_valid = 1'b1;
      @(posedge clk); #1 req_addr = 32'h14;
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("stall_latency", 32'(n), 32'(WS + 1));
      first = rsp_rdata;
      chk("stall_first_rdata", first, 32'hDEAD80EF);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rdata", rsp_rdata, first);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      chk("stall_idle_ready", 32'(req_ready), 32'd1);
      chk("stall_idle_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1 req_valid = 1'b0;
      chk("stall_accept_busy", 32'(busy), 32'd1);
      n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("stall2_latency", 32'(n), 32'(WS + 1));
      model(1'b0, 32'h14, 3'd2, 32'h0, mrd, merr);
      chk("stall2_rdata", rsp_rdata, mrd);
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      $display("txn stall sequence rdata=%h then %h", first, mrd);

      // Reset during ACCESS of a store drops the store.
      model(1'b0, 32'h20, 3'd2, 32'h0, held, merr);
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h20; req_width = 3'd2; req_wdata = 32'h12345678; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      chk("rst_busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      $display("txn reset during store to 0x20");
      txn(1'b0, 32'h20, 3'd2, 32'h0, 0, rd, er);
      chk("rst_old_contents", rd, held);

      // Randomized traffic against the model.
      for (int i = 0; i < 200; i++) begin
         logic we;
         logic [31:0] addr, wd;
         logic [2:0] w;
         int sel;
         we = 1'($urandom_range(0, 1));
         addr = 32'($urandom_range(0, 127));
         if ($urandom_range(0, 7) == 0) addr = addr | (32'($urandom_range(1, 15)) << 10);
         sel = $urandom_range(0, 11);
         w = (sel < 2) ? 3'd0 : (sel < 4) ? 3'd1 : (sel < 7) ? 3'd2 :
             (sel < 8) ? 3'd4 : (sel < 10) ? 3'd5 : (sel < 11) ? 3'd3 : 3'd7;
         wd = $urandom;
         model(we, addr, w, wd, mrd, merr);
         txn(we, addr, w, wd, $urandom_range(0, 3), rd, er);
         chk("rand_rdata", rd, mrd);
         chk("rand_err", 32'(er), 32'(merr));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's load/store/fetch initiator: accepts one request at a time and performs a byte-addressed access into a word array.
- Returns load data sign- or zero-extended per the RV32 funct3 width encoding, after a configurable number of wait states.
- Replaces the direct combinational array indexing in the control path with a valid/ready request/response protocol.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; power of two.
WAIT_STATES, 1, extra cycles spent in ACCESS before the array is touched; range 0..15.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load/fetch
req_addr  input  32  byte address
req_width  input  3  funct3 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_wdata  input  32  store data, right-aligned
rsp_valid  output  1  response present
rsp_ready  input  1  initiator accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  access error; see Optional Feature
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Array contents are not reset.
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we/addr/width/wdata, load wait counter with WAIT_STATES, go to ACCESS.
- ACCESS:
  - req_ready=0.
  - Counter nonzero: decrement and stay.
  - Counter zero: perform the access on this edge and go to RESPOND.
- RESPOND:
  - rsp_valid=1; rsp_rdata and rsp_err held stable.
  - On rsp_ready: return to IDLE, rsp_valid=0 next cycle.
  - A new request cannot be accepted in the same cycle (req_ready=0 in RESPOND).
- Latency:
  - Accept edge to rsp_valid high is WAIT_STATES+1 cycles.
  - Minimum back-to-back throughput is one transaction per WAIT_STATES+3 cycles.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
  - Higher address bits are ignored (wrap modulo DEPTH_WORDS*4) unless the feature is enabled.
- Loads:
  - Select byte/halfword at lane, then extend.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Stores:
  - Byte-enable write; only the addressed lanes change. B writes wdata[7:0], H writes wdata[15:0].
  - rsp_rdata=0.
- Width decode:
  - Codes 011, 110, 111 are illegal: no array write, rsp_rdata=0, rsp_err=1.
  - This applies regardless of the macro.
- Misalignment:
  - H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Handling is governed by the macro below.
- Reset asserted in ACCESS before the commit edge: store is dropped, array unchanged.

Optional Feature:
MEM_RESPONDER_STRICT_EN
- Defined:
  - Misaligned access → rsp_err=1, no write, rdata=0.
  - Any addr bit above log2(DEPTH_WORDS)+1 set → rsp_err=1, no write, rdata=0.
- Undefined:
  - Misaligned access has its offending low bits forced to 0 (aligned down).
  - Out-of-range address wraps.
  - rsp_err is raised only for illegal width codes.

Decomposition:
- Shared package (alongside OpCode/instruction typedefs): MemWidth enum (BITS8, BITS16, BITS32, BITS8U, BITS16U with funct3 values), MemRespState enum (IDLE, ACCESS, RESPOND).
- Sub-module mem_lane_extract, combinational:
  - Inputs: word, lane, width.
  - Outputs: extended data, legal/misaligned flags.
- The top level holds the FSM, counter and array.

Test Plan:
- W store 0xDEADBEEF @0x10, then W load @0x10 with WAIT_STATES=1 → rsp_valid 2 cycles after each accept; load rdata=0xDEADBEEF, err=0.
- B store 0x80 @0x11, then B load @0x11 → 0xFFFFFF80; BU load @0x11 → 0x00000080; W load @0x10 → 0xDEAD80EF.
- H load @0x12 → 0xFFFFDEAD; HU → 0x0000DEAD; H load @0x13 → strict: err=1, rdata=0; non-strict: 0xFFFFDEAD.
- Width code 111 store @0x10 → err=1, subsequent W load returns prior value unchanged.
- Hold rsp_ready=0 for 5 cycles in RESPOND → rsp_valid/rdata stable, req_ready=0, a pending req_valid is not accepted until after the handshake.
- Assert rst_n low during ACCESS of a store 0x12345678 @0x20 → outputs return to reset values immediately; later load @0x20 returns the old contents.
